pwm_deadtime: RTL and testbench

Dead-time insertion stage that sits directly downstream of the single-output PWM state machine. It consumes that block's `y` output as `pwm_in` and drives a complementary high-side/low-side gate pair. A timed FSM guarantees that `hi` and `lo` are never both asserted and that both are low for at least `DEAD_CYCLES` clocks at every hand-over. A latched fault input forces both outputs off until the fault is explicitly cleared.

---
 rtl/pwm_deadtime.sv | 82 ++++++++
 tb/tb_pwm_deadtime.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Dead-time insertion for a single PWM command: drives a complementary hi/lo
// gate pair through timed dead states, with a latched fault that forces both off.
module pwm_deadtime #(
  parameter int DEAD_CYCLES = 4,
  parameter int TW          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pwm_in,
  input  logic fault,
  input  logic fault_clr,
  output logic hi,
  output logic lo,
  output logic dead,
  output logic fault_latched
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO_ON,
    S_DEAD_TO_HI,
    S_HI_ON,
    S_DEAD_TO_LO,
    S_FAULT
  } state_e;

  localparam logic [TW-1:0] T_LAST = TW'(DEAD_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Fault dominates everything, then enable, then the per-state hand-over rules.
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = S_FAULT;
    end else if (!en && state_q != S_FAULT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:       state_d = S_DEAD_TO_LO;
        S_DEAD_TO_LO: begin
          if (pwm_in)              state_d = S_DEAD_TO_HI;
          else if (t_q == T_LAST)  state_d = S_LO_ON;
        end
        S_LO_ON:      if (pwm_in)  state_d = S_DEAD_TO_HI;
        S_DEAD_TO_HI: begin
          if (!pwm_in)             state_d = S_DEAD_TO_LO;
          else if (t_q == T_LAST)  state_d = S_HI_ON;
        end
        S_HI_ON:      if (!pwm_in) state_d = S_DEAD_TO_LO;
        S_FAULT:      if (fault_clr) state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Timer restarts on every state change so each dead interval is measured afresh.
  always_comb begin
    t_d = t_q;
    if (state_d != state_q)  t_d = '0;
    else if (t_q != T_MAX)   t_d = t_q + 1'b1;
  end

  assign hi            = (state_q == S_HI_ON);
  assign lo            = (state_q == S_LO_ON);
  assign dead          = (state_q == S_DEAD_TO_HI) || (state_q == S_DEAD_TO_LO);
  assign fault_latched = (state_q == S_FAULT);

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboarded bench for pwm_deadtime: a behavioural model queues the expected
// outputs per clock; directed windows also count hi/lo/dead cycles.
module tb_pwm_deadtime;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n, en, pwm_in, fault, fault_clr;
  logic hi, lo, dead, fault_latched;

  int total = 0;
  int bad   = 0;
  int n_hi, n_lo, n_dead;

  // model: 0 IDLE, 1 LO_ON, 2 DEAD_TO_HI, 3 HI_ON, 4 DEAD_TO_LO, 5 FAULT
  int m_st = 0;
  int m_t  = 0;
  logic [3:0] exp_q[$];

  pwm_deadtime #(.DEAD_CYCLES(D), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in), .fault(fault),
    .fault_clr(fault_clr), .hi(hi), .lo(lo), .dead(dead),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_t  = 0;
  endtask

  // One clock: predict from the inputs presented now, then compare after the edge.
  task automatic step();
    int nst;
    logic [3:0] e;
    nst = m_st;
    if (fault) nst = 5;
    else if (!en && m_st != 5) nst = 0;
    else begin
      case (m_st)
        0: nst = 4;
        1: if (pwm_in) nst = 2;
        2: if (!pwm_in) nst = 4; else if (m_t >= D - 1) nst = 3;
        3: if (!pwm_in) nst = 4;
        4: if (pwm_in) nst = 2; else if (m_t >= D - 1) nst = 1;
        5: if (fault_clr) nst = 0;
        default: nst = 0;
      endcase
    end
    m_t  = (nst != m_st) ? 0 : ((m_t < 255) ? m_t + 1 : 255);
    m_st = nst;
    exp_q.push_back({nst == 3, nst == 1, nst == 2 || nst == 4, nst == 5});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("outs{hi,lo,dead,flt}", {hi, lo, dead, fault_latched}, e);
    chk("no_overlap", hi & lo, 0);
    n_hi   += hi;
    n_lo   += lo;
    n_dead += dead;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_cnt();
    n_hi = 0; n_lo = 0; n_dead = 0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    clr_cnt();
    #12;
    chk("reset_outs", {hi, lo, dead, fault_latched}, 0);
    rst_n = 1'b1;

    // start-up: full dead interval, then lo steadily
    en = 1'b1;
    clr_cnt();
    steps(10);
    chk("startup_dead", n_dead, 4);
    chk("startup_lo", n_lo, 6);
    chk("startup_hi", n_hi, 0);

    // 16 low / 64 high PWM; measure the second period
    for (int p = 0; p < 3; p++) begin
      if (p == 1) clr_cnt();
      pwm_in = 1'b0; steps(16);
      pwm_in = 1'b1; steps(64);
      if (p == 1) begin
        chk("period_lo", n_lo, 12);
        chk("period_dead", n_dead, 8);
        chk("period_hi", n_hi, 60);
      end
    end

    // short 3-cycle pulse from LO_ON never reaches hi
    pwm_in = 1'b0; steps(12);
    clr_cnt();
    pwm_in = 1'b1; steps(3);
    pwm_in = 1'b0; steps(10);
    chk("pulse_hi", n_hi, 0);
    chk("pulse_dead", n_dead, 7);
    chk("pulse_lo", n_lo, 6);

    // one-cycle fault in HI_ON; en toggling does not exit; clear resumes
    pwm_in = 1'b1; steps(10);
    chk("pre_fault_hi", hi, 1);
    fault = 1'b1; step();
    chk("fault_hi_drop", hi, 0);
    fault = 1'b0; steps(3);
    en = 1'b0; steps(2);
    en = 1'b1; steps(2);
    chk("fault_held", fault_latched, 1);
    pwm_in = 1'b0;
    fault_clr = 1'b1; step();
    fault_clr = 1'b0;
    chk("clr_to_idle", {hi, lo, dead, fault_latched}, 0);
    clr_cnt();
    steps(6);
    chk("resume_dead", n_dead, 4);
    chk("resume_lo", n_lo, 2);

    // fault together with fault_clr stays in FAULT
    fault = 1'b1; step();
    fault_clr = 1'b1; steps(2);
    chk("fault_wins", fault_latched, 1);
    fault = 1'b0; step();
    fault_clr = 1'b0; steps(8);

    // en low during DEAD_TO_HI goes straight to IDLE
    pwm_in = 1'b1; step();
    chk("in_dth", dead, 1);
    en = 1'b0; step();
    chk("en_off_idle", {hi, lo, dead, fault_latched}, 0);
    en = 1'b1; steps(10);

    // asynchronous reset mid-HI_ON
    chk("pre_rst_hi", hi, 1);
    #3 rst_n = 1'b0;
    #1 chk("async_rst_hi", hi, 0);
    chk("async_rst_outs", {hi, lo, dead, fault_latched}, 0);
    model_reset();
    #2 rst_n = 1'b1;
    en = 1'b0; step();
    chk("post_rst_idle", {hi, lo, dead, fault_latched}, 0);

    // random mix against the model
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 19) != 0);
      fault     = ($urandom_range(0, 29) == 0);
      fault_clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
